// File: rtl/ddr3_pkg.sv
// Shared definitions for the two-port DDR3 request arbiter: FSM encoding and
// port-index / request-ID width constants.
package ddr3_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WDAT = 2'd2
    } state_t;

    localparam int PORT_IDX_W = 1;
    localparam int DEF_REQID  = 4;
endpackage

// File: rtl/ddr3_rr_arb2.sv
// Two-input arbiter: round-robin on ties, or fixed priority to input 0 when
// DDR3_ARB_FIXED_PRIO_EN is defined.
module ddr3_rr_arb2
    import ddr3_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_grant,
    output logic       o_any
);
    assign o_any = |i_req;

`ifdef DDR3_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = &{1'b0, clock, reset, i_take};
    assign o_grant  = ~i_req[0];
`else
    logic r_last_grant;

    always_ff @(posedge clock) begin
        if (reset)
            r_last_grant <= 1'b1;
        else if (i_take)
            r_last_grant <= o_grant;
    end

    // On a tie the port that did not win last time goes first.
    always_comb begin
        if (&i_req)
            o_grant = ~r_last_grant;
        else
            o_grant = ~i_req[0];
    end
`endif
endmodule

// File: rtl/ddr3_mem_arbiter.sv
// Two-port DDR3 request/write arbiter with ID-routed read responses.
// Optional: DDR3_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
//   state   | meaning
//   ST_IDLE | waiting for a pending request, arbitrate
//   ST_REQ  | granted request mirrored downstream until accepted
//   ST_WDAT | write beats of the granted port forwarded until last
module ddr3_mem_arbiter
    import ddr3_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MASKS = WIDTH / 8,
    parameter int ADDRS = 32,
    parameter int REQID = DEF_REQID
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_store_i,
    input  logic             req0_fetch_i,
    output logic             req0_accept_o,
    input  logic [ADDRS-1:0] req0_addr_i,
    input  logic [REQID-1:0] req0_id_i,
    input  logic             req0_wvalid_i,
    output logic             req0_wready_o,
    input  logic             req0_wlast_i,
    input  logic [MASKS-1:0] req0_wmask_i,
    input  logic [WIDTH-1:0] req0_wdata_i,
    output logic             req0_rvalid_o,
    input  logic             req0_rready_i,
    output logic             req0_rlast_o,
    output logic [REQID-1:0] req0_rid_o,
    output logic [WIDTH-1:0] req0_rdata_o,
    input  logic             req1_store_i,
    input  logic             req1_fetch_i,
    output logic             req1_accept_o,
    input  logic [ADDRS-1:0] req1_addr_i,
    input  logic [REQID-1:0] req1_id_i,
    input  logic             req1_wvalid_i,
    output logic             req1_wready_o,
    input  logic             req1_wlast_i,
    input  logic [MASKS-1:0] req1_wmask_i,
    input  logic [WIDTH-1:0] req1_wdata_i,
    output logic             req1_rvalid_o,
    input  logic             req1_rready_i,
    output logic             req1_rlast_o,
    output logic [REQID-1:0] req1_rid_o,
    output logic [WIDTH-1:0] req1_rdata_o,
    output logic             mem_store_o,
    output logic             mem_fetch_o,
    input  logic             mem_accept_i,
    output logic [ADDRS-1:0] mem_addr_o,
    output logic [REQID:0]   mem_req_id_o,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic             mem_last_o,
    output logic [MASKS-1:0] mem_wrmask_o,
    output logic [WIDTH-1:0] mem_wrdata_o,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic             mem_last_i,
    input  logic [REQID:0]   mem_resp_id_i,
    input  logic [WIDTH-1:0] mem_rddata_i
);
    state_t                r_state;
    state_t                w_next;
    logic [PORT_IDX_W-1:0] r_grant;
    logic                  w_arb_grant, w_arb_any, w_take;
    logic                  w_g_store, w_g_fetch, w_g_wvalid, w_g_wlast;
    logic                  w_in_req, w_in_wdat, w_mem_acc, w_beat_last, w_rsel;

    ddr3_rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .i_req   ({req1_store_i | req1_fetch_i, req0_store_i | req0_fetch_i}),
        .i_take  (w_take),
        .o_grant (w_arb_grant),
        .o_any   (w_arb_any)
    );

    assign w_g_store  = r_grant[0] ? req1_store_i  : req0_store_i;
    assign w_g_fetch  = r_grant[0] ? req1_fetch_i  : req0_fetch_i;
    assign w_g_wvalid = r_grant[0] ? req1_wvalid_i : req0_wvalid_i;
    assign w_g_wlast  = r_grant[0] ? req1_wlast_i  : req0_wlast_i;

    assign w_take      = (r_state == ST_IDLE) && w_arb_any;
    assign w_in_req    = !reset && (r_state == ST_REQ);
    assign w_in_wdat   = !reset && (r_state == ST_WDAT);
    assign w_mem_acc   = mem_accept_i && (w_g_store || w_g_fetch);
    assign w_beat_last = w_g_wvalid && mem_ready_i && w_g_wlast;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_next;
            if (w_take)
                r_grant <= w_arb_grant;
        end
    end

    // A request dropped while mirrored falls back to IDLE without an accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_arb_any) w_next = ST_REQ;
            ST_REQ: begin
                if (w_mem_acc)
                    w_next = w_g_store ? ST_WDAT : ST_IDLE;
                else if (!w_g_store && !w_g_fetch)
                    w_next = ST_IDLE;
            end
            ST_WDAT: if (w_beat_last) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_o    = r_grant[0] ? req1_addr_i  : req0_addr_i;
        mem_req_id_o  = {r_grant, r_grant[0] ? req1_id_i : req0_id_i};
        mem_wrmask_o  = r_grant[0] ? req1_wmask_i : req0_wmask_i;
        mem_wrdata_o  = r_grant[0] ? req1_wdata_i : req0_wdata_i;
        mem_store_o   = w_in_req && w_g_store;
        mem_fetch_o   = w_in_req && w_g_fetch && !w_g_store;
        req0_accept_o = w_in_req && w_mem_acc && !r_grant[0];
        req1_accept_o = w_in_req && w_mem_acc &&  r_grant[0];
        mem_valid_o   = w_in_wdat && w_g_wvalid;
        mem_last_o    = w_in_wdat && w_g_wlast;
        req0_wready_o = w_in_wdat && mem_ready_i && !r_grant[0];
        req1_wready_o = w_in_wdat && mem_ready_i &&  r_grant[0];
    end

    // Read responses bypass the FSM; the top ID bit picks the port.
    assign w_rsel        = mem_resp_id_i[REQID];
    assign req0_rvalid_o = !reset && mem_valid_i && !w_rsel;
    assign req1_rvalid_o = !reset && mem_valid_i &&  w_rsel;
    assign req0_rlast_o  = !reset && mem_last_i  && !w_rsel;
    assign req1_rlast_o  = !reset && mem_last_i  &&  w_rsel;
    assign mem_ready_o   = !reset && (w_rsel ? req1_rready_i : req0_rready_i);
    assign req0_rid_o    = mem_resp_id_i[REQID-1:0];
    assign req1_rid_o    = mem_resp_id_i[REQID-1:0];
    assign req0_rdata_o  = mem_rddata_i;
    assign req1_rdata_o  = mem_rddata_i;
endmodule
